// File: rtl/uart_pkg.sv
// Shared UART definitions: frame decoder state encoding, default sync marker
// and the bit-period helper used by the rx/tx/frame parameter math.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHK,
    SEND
  } frame_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Byte stream from uart_rx into the frame decoder, the released payload stream
// and the decoder status pulses.
interface uart_frame_rx_if;

  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_break;

  logic       frm_valid;
  logic [7:0] frm_data;
  logic       frm_last;
  logic       frm_ready;
  logic [7:0] frm_len;

  logic       err_chk;
  logic       err_len;
  logic       err_tmo;
  logic       err_ovr;
  logic       busy;

  // master: the frame decoder itself
  modport master (
    input  uart_rx_valid, uart_rx_data, uart_rx_break, frm_ready,
    output frm_valid, frm_data, frm_last, frm_len,
    output err_chk, err_len, err_tmo, err_ovr, busy
  );

  // slave: byte source plus payload consumer
  modport slave (
    output uart_rx_valid, uart_rx_data, uart_rx_break, frm_ready,
    input  frm_valid, frm_data, frm_last, frm_len,
    input  err_chk, err_len, err_tmo, err_ovr, busy
  );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: synchronous write, combinational read,
// storage deliberately left without reset.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame decoder: SYNC, LEN, payload[LEN], CHK (XOR of LEN and payload).
// Good frames are replayed from the buffer on a valid/ready stream.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int         CLK_HZ        = 50_000_000,
  parameter int         BIT_RATE      = 115200,
  parameter int         MAX_LEN       = 16,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_BYTES = 4
) (
  input logic             clk,
  input logic             resetn,
  uart_frame_rx_if.master bus
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * CYCLES_PER_BIT;
  localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  // Expiry is judged on the edge that would bring the count to TIMEOUT_CYCLES,
  // so a byte sampled on that same edge still wins.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  frame_state_t     state_reg, state_next;
  logic [7:0]       len_reg, len_next;
  logic [7:0]       chk_reg, chk_next;
  logic [7:0]       wr_idx_reg, wr_idx_next;
  logic [7:0]       rd_idx_reg, rd_idx_next;
  logic [TMO_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       frm_len_reg, frm_len_next;
  logic             err_chk_reg, err_chk_next;
  logic             err_len_reg, err_len_next;
  logic             err_tmo_reg, err_tmo_next;
  logic             err_ovr_reg, err_ovr_next;

  logic             buf_we;
  logic [7:0]       rd_data;
  logic             sending;
  logic             receiving;

  assign sending   = (state_reg == SEND);
  assign receiving = (state_reg == LEN) || (state_reg == PAYLOAD) || (state_reg == CHK);

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    chk_next     = chk_reg;
    wr_idx_next  = wr_idx_reg;
    rd_idx_next  = rd_idx_reg;
    cnt_next     = '0;
    frm_len_next = frm_len_reg;
    err_chk_next = 1'b0;
    err_len_next = 1'b0;
    err_tmo_next = 1'b0;
    err_ovr_next = 1'b0;
    buf_we       = 1'b0;

    if (state_reg == IDLE) begin
      if (bus.uart_rx_valid && (bus.uart_rx_data == SYNC_BYTE)) begin
        state_next = LEN;
      end
    end else if (receiving) begin
      cnt_next = cnt_reg + 1'b1;
      // Break has priority over a byte arriving in the same cycle.
      if (bus.uart_rx_break) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else if (bus.uart_rx_valid) begin
        cnt_next = '0;
        if (state_reg == LEN) begin
          if ((bus.uart_rx_data == 8'd0) || (bus.uart_rx_data > 8'(MAX_LEN))) begin
            err_len_next = 1'b1;
            state_next   = IDLE;
          end else begin
            len_next    = bus.uart_rx_data;
            chk_next    = bus.uart_rx_data;
            wr_idx_next = 8'd0;
            state_next  = PAYLOAD;
          end
        end else if (state_reg == PAYLOAD) begin
          buf_we      = 1'b1;
          chk_next    = chk_reg ^ bus.uart_rx_data;
          wr_idx_next = wr_idx_reg + 8'd1;
          if (wr_idx_reg == len_reg - 8'd1) begin
            state_next = CHK;
          end
        end else begin
          if (bus.uart_rx_data == chk_reg) begin
            rd_idx_next  = 8'd0;
            frm_len_next = len_reg;
            state_next   = SEND;
          end else begin
            err_chk_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end else if (cnt_reg == TMO_LAST) begin
        err_tmo_next = 1'b1;
        state_next   = IDLE;
        cnt_next     = '0;
      end
    end else if (sending) begin
      err_ovr_next = bus.uart_rx_valid;
      if (bus.frm_ready) begin
        if (rd_idx_reg == len_reg - 8'd1) begin
          rd_idx_next  = 8'd0;
          frm_len_next = 8'd0;
          state_next   = IDLE;
        end else begin
          rd_idx_next = rd_idx_reg + 8'd1;
        end
      end
    end else begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      len_reg     <= 8'd0;
      chk_reg     <= 8'd0;
      wr_idx_reg  <= 8'd0;
      rd_idx_reg  <= 8'd0;
      cnt_reg     <= '0;
      frm_len_reg <= 8'd0;
      err_chk_reg <= 1'b0;
      err_len_reg <= 1'b0;
      err_tmo_reg <= 1'b0;
      err_ovr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      chk_reg     <= chk_next;
      wr_idx_reg  <= wr_idx_next;
      rd_idx_reg  <= rd_idx_next;
      cnt_reg     <= cnt_next;
      frm_len_reg <= frm_len_next;
      err_chk_reg <= err_chk_next;
      err_len_reg <= err_len_next;
      err_tmo_reg <= err_tmo_next;
      err_ovr_reg <= err_ovr_next;
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_addr (wr_idx_reg[IDX_W-1:0]),
    .wr_data (bus.uart_rx_data),
    .rd_addr (rd_idx_reg[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  // Data is masked outside SEND so the unreset buffer never shows on the port.
  assign bus.frm_valid = sending;
  assign bus.frm_data  = sending ? rd_data : 8'h00;
  assign bus.frm_last  = sending && (rd_idx_reg == len_reg - 8'd1);
  assign bus.frm_len   = frm_len_reg;
  assign bus.err_chk   = err_chk_reg;
  assign bus.err_len   = err_len_reg;
  assign bus.err_tmo   = err_tmo_reg;
  assign bus.err_ovr   = err_ovr_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scenario bench for uart_frame_rx: directed frames plus randomized frames
// checked against a payload/XOR reference model.
module tb_uart_frame_rx;

  typedef logic [7:0] byte_q_t[$];

  localparam int T = 4 * 10 * (50_000_000 / 115200);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  uart_frame_rx_if bus();

  uart_frame_rx #(
    .CLK_HZ        (50_000_000),
    .BIT_RATE      (115200),
    .MAX_LEN       (16),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_BYTES (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] out_q[$];
  bit         last_q[$];
  logic [7:0] len_q[$];
  int         out_cyc_q[$];
  int         n_chk, n_len, n_tmo, n_ovr;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are observed on the falling edge, half a cycle from any update.
  always @(negedge clk) begin
    if (bus.frm_valid && bus.frm_ready) begin
      out_q.push_back(bus.frm_data);
      last_q.push_back(bus.frm_last);
      len_q.push_back(bus.frm_len);
      out_cyc_q.push_back(cyc);
    end
    if (bus.err_chk) n_chk++;
    if (bus.err_len) n_len++;
    if (bus.err_tmo) n_tmo++;
    if (bus.err_ovr) n_ovr++;
  end

  function automatic logic [7:0] frame_xor(input byte_q_t pl);
    logic [7:0] x;
    x = 8'(pl.size());
    foreach (pl[i]) x ^= pl[i];
    return x;
  endfunction

  function automatic byte_q_t make_frame(input byte_q_t pl, input logic [7:0] chk_flip);
    byte_q_t f;
    f.push_back(8'hA5);
    f.push_back(8'(pl.size()));
    foreach (pl[i]) f.push_back(pl[i]);
    f.push_back(frame_xor(pl) ^ chk_flip);
    return f;
  endfunction

  task automatic clear_mon();
    out_q.delete(); last_q.delete(); len_q.delete(); out_cyc_q.delete();
    n_chk = 0; n_len = 0; n_tmo = 0; n_ovr = 0;
  endtask

  // Every task starts and ends 1 ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.uart_rx_data = b;
    bus.uart_rx_valid = 1'b1;
    tick(1);
    bus.uart_rx_valid = 1'b0;
  endtask

  task automatic send_seq(input byte_q_t s, input int max_gap);
    foreach (s[i]) begin
      send_byte(s[i]);
      if (max_gap > 0 && i != s.size() - 1) tick($urandom_range(0, max_gap));
    end
  endtask

  task automatic wait_idle(input int budget, input bit rnd_ready);
    int k;
    k = 0;
    while (bus.busy && k < budget) begin
      if (rnd_ready) bus.frm_ready = 1'($urandom_range(0, 1));
      tick(1);
      k++;
    end
    bus.frm_ready = 1'b1;
    checks++;
    if (bus.busy) begin
      errors++;
      $display("FAIL wait_idle: busy=%0d after %0d cycles, required 0", bus.busy, budget);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(3);
    checks++;
    if ({bus.frm_valid, bus.frm_data, bus.frm_last, bus.frm_len, bus.err_chk, bus.err_len,
         bus.err_tmo, bus.err_ovr, bus.busy} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h last=%b len=%h errs=%b%b%b%b busy=%b, required all 0",
               bus.frm_valid, bus.frm_data, bus.frm_last, bus.frm_len, bus.err_chk, bus.err_len,
               bus.err_tmo, bus.err_ovr, bus.busy);
    end
    resetn = 1'b1;
    tick(2);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b required 0", bus.busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_good_frame();
    byte_q_t f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    logic [7:0] exp_d[3] = '{8'h11, 8'h22, 8'h33};
    clear_mon();
    bus.frm_ready = 1'b1;
    send_seq(f, 0);
    checks++;
    if ({bus.frm_valid, bus.frm_data, bus.frm_last, bus.frm_len} !== {1'b1, 8'h11, 1'b0, 8'h03}) begin
      errors++;
      $display("FAIL good_first: valid/data/last/len=%b/%h/%b/%h required 1/11/0/03",
               bus.frm_valid, bus.frm_data, bus.frm_last, bus.frm_len);
    end
    wait_idle(20, 1'b0);
    tick(1);
    checks++;
    if (out_q.size() != 3) begin
      errors++;
      $display("FAIL good_count: got %0d required 3", out_q.size());
    end
    foreach (exp_d[i]) begin
      if (i < out_q.size()) begin
        checks++;
        if ({out_q[i], last_q[i], len_q[i]} !== {exp_d[i], (i == 2), 8'h03} ||
            out_cyc_q[i] != out_cyc_q[0] + i) begin
          errors++;
          $display("FAIL good_byte%0d: data=%h last=%b len=%h dcyc=%0d required %h/%b/03/%0d",
                   i, out_q[i], last_q[i], len_q[i], out_cyc_q[i] - out_cyc_q[0], exp_d[i], (i == 2), i);
        end
      end
    end
    checks++;
    if (n_chk + n_len + n_tmo + n_ovr != 0) begin
      errors++;
      $display("FAIL good_errs: got chk=%0d len=%0d tmo=%0d ovr=%0d required none", n_chk, n_len, n_tmo, n_ovr);
    end
    $display("test_good_frame: %0d bytes out", out_q.size());
  endtask

  task automatic test_bad_checksum();
    byte_q_t f1 = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    byte_q_t f2 = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    clear_mon();
    send_seq(f1, 1);
    tick(4);
    checks++;
    if (n_chk != 1 || out_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_chk: got err_chk=%0d outs=%0d busy=%b required 1/0/0", n_chk, out_q.size(), bus.busy);
    end
    send_seq(f2, 0);
    wait_idle(20, 1'b0);
    tick(1);
    checks++;
    if (out_q.size() != 1 || out_q[0] !== 8'h7E || last_q[0] !== 1'b1 || len_q[0] !== 8'h01) begin
      errors++;
      $display("FAIL after_bad_chk: outs=%0d first=%h required 1 byte 7E last=1 len=01",
               out_q.size(), (out_q.size() > 0) ? out_q[0] : 8'hxx);
    end
    $display("test_bad_checksum: err_chk=%0d", n_chk);
  endtask

  task automatic test_illegal_len();
    byte_q_t f = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'hA5, 8'h11, 8'h33, 8'h44, 8'h55};
    clear_mon();
    send_seq(f, 0);
    tick(3);
    checks++;
    if (n_len != 2 || bus.busy !== 1'b0 || out_q.size() != 0 || n_chk != 0) begin
      errors++;
      $display("FAIL illegal_len: got err_len=%0d busy=%b outs=%0d err_chk=%0d required 2/0/0/0",
               n_len, bus.busy, out_q.size(), n_chk);
    end
    $display("test_illegal_len: err_len=%0d", n_len);
  endtask

  task automatic test_timeout();
    byte_q_t f = '{8'hA5, 8'h02, 8'h11};
    int first;
    logic busy_pre, busy_at;
    clear_mon();
    send_seq(f, 0);
    first = -1; busy_pre = 1'bx; busy_at = 1'bx;
    for (int k = 1; k <= T + 3; k++) begin
      tick(1);
      if (k == T - 1) busy_pre = bus.busy;
      if (bus.err_tmo && first < 0) begin first = k; busy_at = bus.busy; end
    end
    checks++;
    if (first != T || busy_pre !== 1'b1 || busy_at !== 1'b0 || n_tmo != 1) begin
      errors++;
      $display("FAIL timeout: first=%0d busy_pre=%b busy_at=%b pulses=%0d required %0d/1/0/1",
               first, busy_pre, busy_at, n_tmo, T);
    end
    clear_mon();
    send_seq(f, 0);
    tick(T - 2);
    send_byte(8'h22);
    tick(T - 1);
    send_byte(8'h02 ^ 8'h11 ^ 8'h22);
    checks++;
    if (n_tmo != 0 || bus.frm_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_in_time: err_tmo=%0d frm_valid=%b required 0/1", n_tmo, bus.frm_valid);
    end
    wait_idle(20, 1'b0);
    tick(1);
    checks++;
    if (out_q.size() != 2 || out_q[0] !== 8'h11 || out_q[1] !== 8'h22 || last_q[1] !== 1'b1) begin
      errors++;
      $display("FAIL timeout_payload: outs=%0d required 11 22 with last", out_q.size());
    end
    $display("test_timeout: first err_tmo at %0d cycles", first);
  endtask

  task automatic test_backpressure();
    byte_q_t pl = '{8'hAA, 8'hBB, 8'hCC};
    byte_q_t f;
    f = make_frame(pl, 8'h00);
    clear_mon();
    bus.frm_ready = 1'b0;
    send_seq(f, 0);
    tick(2);
    send_byte(8'hA5);
    tick(1);
    send_byte(8'h55);
    tick(2);
    checks++;
    if (n_ovr != 2) begin
      errors++;
      $display("FAIL bp_ovr: got %0d pulses required 2", n_ovr);
    end
    checks++;
    if ({bus.frm_valid, bus.frm_data, bus.frm_last, bus.frm_len, bus.busy} !== {1'b1, 8'hAA, 1'b0, 8'h03, 1'b1}) begin
      errors++;
      $display("FAIL bp_hold: valid/data/last/len/busy=%b/%h/%b/%h/%b required 1/AA/0/03/1",
               bus.frm_valid, bus.frm_data, bus.frm_last, bus.frm_len, bus.busy);
    end
    bus.frm_ready = 1'b1;
    wait_idle(20, 1'b0);
    tick(1);
    checks++;
    if (out_q.size() != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d required 3", out_q.size());
    end
    foreach (pl[i]) begin
      if (i < out_q.size()) begin
        checks++;
        if ({out_q[i], last_q[i]} !== {pl[i], (i == 2)}) begin
          errors++;
          $display("FAIL bp_byte%0d: got %h last=%b required %h last=%b", i, out_q[i], last_q[i], pl[i], (i == 2));
        end
      end
    end
    $display("test_backpressure: err_ovr=%0d", n_ovr);
  endtask

  task automatic test_break_reset();
    byte_q_t f1 = '{8'hA5, 8'h04, 8'h01, 8'h02};
    byte_q_t f2 = '{8'hA5, 8'h03, 8'h01};
    byte_q_t f3 = '{8'hA5, 8'h02, 8'h01, 8'h02};
    byte_q_t pl = '{8'h5A, 8'hC3};
    clear_mon();
    send_seq(f1, 0);
    bus.uart_rx_break = 1'b1;
    tick(1);
    bus.uart_rx_break = 1'b0;
    checks++;
    if ({bus.frm_valid, bus.frm_data, bus.frm_last, bus.frm_len, bus.busy} !== 19'd0) begin
      errors++;
      $display("FAIL break_idle: busy=%b valid=%b required 0/0", bus.busy, bus.frm_valid);
    end
    send_seq(f2, 0);
    bus.uart_rx_data = 8'h02;
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_break = 1'b1;
    tick(1);
    bus.uart_rx_valid = 1'b0;
    bus.uart_rx_break = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL break_with_byte: busy=%b required 0", bus.busy);
    end
    send_seq(f3, 0);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy: busy=%b required 1", bus.busy);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.frm_valid, bus.frm_data, bus.frm_last, bus.frm_len, bus.err_chk, bus.err_len,
         bus.err_tmo, bus.err_ovr, bus.busy} !== 23'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b valid=%b len=%h required all 0", bus.busy, bus.frm_valid, bus.frm_len);
    end
    tick(2);
    resetn = 1'b1;
    tick(1);
    send_seq(make_frame(pl, 8'h00), 0);
    wait_idle(20, 1'b0);
    tick(1);
    checks++;
    if (out_q.size() != 2 || out_q[0] !== 8'h5A || out_q[1] !== 8'hC3 || last_q[1] !== 1'b1 || len_q[0] !== 8'h02) begin
      errors++;
      $display("FAIL break_reset_next: outs=%0d required 5A C3 last len=02", out_q.size());
    end
    checks++;
    if (n_chk + n_len + n_tmo + n_ovr != 0) begin
      errors++;
      $display("FAIL break_reset_errs: chk=%0d len=%0d tmo=%0d ovr=%0d required none", n_chk, n_len, n_tmo, n_ovr);
    end
    $display("test_break_reset: %0d bytes out", out_q.size());
  endtask

  task automatic test_random();
    logic [7:0] exp_d[$];
    bit         exp_last[$];
    logic [7:0] exp_len[$];
    int         exp_chk;
    byte_q_t    pl;
    int         len;
    logic [7:0] flip;
    clear_mon();
    exp_chk = 0;
    for (int fr = 0; fr < 24; fr++) begin
      pl.delete();
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      if (flip != 8'h00) begin
        exp_chk++;
      end else begin
        foreach (pl[i]) begin
          exp_d.push_back(pl[i]);
          exp_last.push_back(i == len - 1);
          exp_len.push_back(8'(len));
        end
      end
      send_seq(make_frame(pl, flip), 2);
      wait_idle(400, 1'b1);
      tick(1);
    end
    checks++;
    if (out_q.size() != exp_d.size() || n_chk != exp_chk) begin
      errors++;
      $display("FAIL rand_totals: bytes=%0d err_chk=%0d required %0d/%0d", out_q.size(), n_chk, exp_d.size(), exp_chk);
    end
    foreach (exp_d[i]) begin
      if (i < out_q.size()) begin
        checks++;
        if ({out_q[i], last_q[i], len_q[i]} !== {exp_d[i], exp_last[i], exp_len[i]}) begin
          errors++;
          $display("FAIL rand_byte%0d: got %h/%b/%h required %h/%b/%h",
                   i, out_q[i], last_q[i], len_q[i], exp_d[i], exp_last[i], exp_len[i]);
        end
      end
    end
    $display("test_random: %0d bytes, %0d bad frames", exp_d.size(), exp_chk);
  endtask

  initial begin
    bus.uart_rx_valid = 1'b0;
    bus.uart_rx_data  = 8'h00;
    bus.uart_rx_break = 1'b0;
    bus.frm_ready     = 1'b1;
    #1;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_illegal_len();
    test_timeout();
    test_backpressure();
    test_break_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
